// File: rtl/alu32_seq_if.sv
// Operand/opcode request channel and result channel of the multi-cycle ALU.
// master drives requests and accepts results; slave is the ALU.
interface alu32_seq_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] r;
   logic             zero;
   logic             overflow;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, r, zero, overflow
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, r, zero, overflow
   );
endinterface

// File: rtl/alu32_seq.sv
// Multi-cycle handshaked ALU: single-cycle logic/arith ops, iterative shift-add MULT.
// Result is held in DONE until the consumer takes it; op_count tallies consumed results.
module alu32_seq #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   alu32_seq_if.slave       bus,
   output logic [CNT_W-1:0] op_count
);
   localparam int unsigned STEP_W = $clog2(WIDTH);
   localparam int unsigned PROD_W = 2 * WIDTH;

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_XOR  = 3'b001,
      OP_SUB  = 3'b010,
      OP_MULT = 3'b011,
      OP_SLT  = 3'b100,
      OP_NOR  = 3'b101,
      OP_AND  = 3'b110,
      OP_OR   = 3'b111
   } op_t;

   state_t              state_q, state_d;
   logic [PROD_W-1:0]   mcand_q, mcand_d;
   logic [PROD_W-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]    mplier_q, mplier_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic [WIDTH-1:0]    r_q, r_d;
   logic                zero_q, zero_d;
   logic                ovf_q, ovf_d;
   logic                in_ready_q, in_ready_d;
   logic                out_valid_q, out_valid_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic [WIDTH-1:0]    alu_r_c;
   logic                alu_ovf_c;
   logic                slt_c;
   logic [PROD_W-1:0]   acc_sum_c;

   // Single-cycle ops evaluated straight off the request bus at the accept edge
   always_comb begin
      alu_r_c   = '0;
      alu_ovf_c = 1'b0;
      slt_c     = $signed(bus.a) < $signed(bus.b);
      case (bus.op)
         OP_ADD: begin
            alu_r_c   = bus.a + bus.b;
            alu_ovf_c = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                        (alu_r_c[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_r_c   = bus.a - bus.b;
            alu_ovf_c = (bus.a[WIDTH-1] == ~bus.b[WIDTH-1]) &&
                        (alu_r_c[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_XOR:  alu_r_c = bus.a ^ bus.b;
         OP_SLT:  alu_r_c = WIDTH'(slt_c);
         OP_NOR:  alu_r_c = ~(bus.a | bus.b);
         OP_AND:  alu_r_c = bus.a & bus.b;
         OP_OR:   alu_r_c = bus.a | bus.b;
         default: alu_r_c = '0;
      endcase
   end

   assign acc_sum_c = acc_q + (mplier_q[0] ? mcand_q : '0);

   // Next-state and datapath updates
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      mplier_d = mplier_q;
      step_d   = step_q;
      r_d      = r_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      cnt_d    = cnt_q;

      case (state_q)
         IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               if (bus.op == OP_MULT) begin
                  mcand_d  = PROD_W'(bus.a);
                  mplier_d = bus.b;
                  acc_d    = '0;
                  step_d   = '0;
                  state_d  = MUL;
               end else begin
                  r_d     = alu_r_c;
                  zero_d  = (alu_r_c == '0);
                  ovf_d   = alu_ovf_c;
                  state_d = DONE;
               end
            end
         end
         MUL: begin
            acc_d    = acc_sum_c;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            step_d   = step_q + STEP_W'(1);
            // Last iteration publishes straight from the adder output
            if (step_q == STEP_W'(WIDTH - 1)) begin
               r_d     = acc_sum_c[WIDTH-1:0];
               zero_d  = (acc_sum_c[WIDTH-1:0] == '0);
               ovf_d   = |acc_sum_c[PROD_W-1:WIDTH];
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         mcand_q     <= '0;
         acc_q       <= '0;
         mplier_q    <= '0;
         step_q      <= '0;
         r_q         <= '0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         mcand_q     <= mcand_d;
         acc_q       <= acc_d;
         mplier_q    <= mplier_d;
         step_q      <= step_d;
         r_q         <= r_d;
         zero_q      <= zero_d;
         ovf_q       <= ovf_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.r         = r_q;
   assign bus.zero      = zero_q;
   assign bus.overflow  = ovf_q;
   assign op_count      = cnt_q;
endmodule

// File: tb/tb_alu32_seq.sv
// Directed-vector bench for alu32_seq: latency, arithmetic corner cases,
// backpressure, and reset during a multiply.
module tb_alu32_seq;
   localparam int unsigned WIDTH = 32;
   localparam int unsigned CNT_W = 16;

   localparam logic [2:0] ADD  = 3'b000;
   localparam logic [2:0] XOR  = 3'b001;
   localparam logic [2:0] SUB  = 3'b010;
   localparam logic [2:0] MULT = 3'b011;
   localparam logic [2:0] SLT  = 3'b100;
   localparam logic [2:0] NOR  = 3'b101;
   localparam logic [2:0] AND  = 3'b110;
   localparam logic [2:0] OR   = 3'b111;

   logic             clk = 1'b0;
   logic             reset;
   logic [CNT_W-1:0] op_count;

   alu32_seq_if #(.WIDTH(WIDTH)) bus ();

   alu32_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus.slave),
      .op_count (op_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int exp_cnt  = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // Present a request and return just after the edge that accepts it
   task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      bus.in_valid = 1'b1;
      bus.op       = op;
      bus.a        = a;
      bus.b        = b;
      for (int i = 0; i < 50 && !bus.in_ready; i++) tick();
      check({tag, "_accept_ready"}, 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      bus.a        = 32'hDEAD_BEEF;
      bus.b        = 32'hDEAD_BEEF;
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_r, input logic exp_z,
                         input logic exp_o, input int exp_lat);
      int lat;
      bit busy_ready;
      bus.out_ready = 1'b1;
      issue(tag, op, a, b);
      lat        = 1;
      busy_ready = 1'b0;
      while (!bus.out_valid && lat < 100) begin
         if (bus.in_ready) busy_ready = 1'b1;
         tick();
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_r"}, bus.r, exp_r);
      check({tag, "_zero"}, 32'(bus.zero), 32'(exp_z));
      check({tag, "_overflow"}, 32'(bus.overflow), 32'(exp_o));
      check({tag, "_busy_in_ready"}, 32'(busy_ready | bus.in_ready), 32'd0);
      tick();
      exp_cnt++;
      check({tag, "_op_count"}, 32'(op_count), 32'(exp_cnt));
      check({tag, "_out_valid_drop"}, 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.op        = 3'b000;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_r", bus.r, 32'd0);
      check("rst_zero", 32'(bus.zero), 32'd0);
      check("rst_overflow", 32'(bus.overflow), 32'd0);
      check("rst_op_count", 32'(op_count), 32'd0);

      run_op("add_basic", ADD, 32'h3333_3333, 32'h3333_3333, 32'h6666_6666, 1'b0, 1'b0, 1);
      run_op("add_neg", ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, 1);
      run_op("add_ovf", ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1);
      run_op("sub_zero", SUB, 32'h5555_5555, 32'h5555_5555, 32'h0000_0000, 1'b1, 1'b0, 1);
      run_op("sub_ovf", SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1);
      run_op("slt_true", SLT, 32'h0000_0333, 32'h3333_3333, 32'h0000_0001, 1'b0, 1'b0, 1);
      run_op("slt_false", SLT, 32'h5555_5555, 32'h1D55_1D55, 32'h0000_0000, 1'b1, 1'b0, 1);
      run_op("slt_signed", SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1);
      run_op("nor", NOR, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F, 1'b0, 1'b0, 1);
      run_op("or", OR, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0, 1);
      run_op("mult_big", MULT, 32'h8112_2500, 32'h0060_0000, 32'hE000_0000, 1'b0, 1'b1, 33);
      run_op("mult_small", MULT, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 1'b0, 1'b0, 33);
      run_op("mult_by_zero", MULT, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 33);

      // out_ready while idle must not count anything
      bus.out_ready = 1'b1;
      tick();
      tick();
      check("idle_out_ready_count", 32'(op_count), 32'(exp_cnt));
      check("idle_out_ready_valid", 32'(bus.out_valid), 32'd0);

      // Backpressure: result held, new requests ignored until consumed
      bus.out_ready = 1'b0;
      issue("bp", XOR, 32'hB333_3333, 32'h3333_3333);
      bus.in_valid = 1'b1;
      bus.op       = ADD;
      bus.a        = 32'h0000_0001;
      bus.b        = 32'h0000_0001;
      for (int i = 0; i < 5; i++) begin
         check("bp_r_hold", bus.r, 32'h8000_0000);
         check("bp_out_valid", 32'(bus.out_valid), 32'd1);
         check("bp_in_ready", 32'(bus.in_ready), 32'd0);
         tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      check("bp_count_before", 32'(op_count), 32'(exp_cnt));
      tick();
      exp_cnt++;
      check("bp_count_after", 32'(op_count), 32'(exp_cnt));
      check("bp_r_kept", bus.r, 32'h8000_0000);
      check("bp_in_ready_back", 32'(bus.in_ready), 32'd1);
      tick();
      check("bp_no_ghost_op", 32'(bus.out_valid), 32'd0);

      // Reset in the 10th cycle of a multiply aborts it
      issue("rst_mul", MULT, 32'h0000_0007, 32'h0000_0009);
      for (int i = 0; i < 9; i++) tick();
      check("rst_mul_busy", 32'(bus.in_ready), 32'd0);
      reset = 1'b1;
      tick();
      reset   = 1'b0;
      exp_cnt = 0;
      check("rst_mul_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_mul_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_mul_r", bus.r, 32'd0);
      check("rst_mul_op_count", 32'(op_count), 32'd0);
      tick();
      check("rst_mul_no_result", 32'(bus.out_valid), 32'd0);

      run_op("and_after_rst", AND, 32'hB333_3333, 32'h3333_3333, 32'h3333_3333, 1'b0, 1'b0, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/alu32_seq.md
Name: alu32_seq

Overview:
Multi-cycle, handshaked 32-bit ALU. It is the responding end of the ALU operand/opcode interface, and it uses the same 3-bit opcode map as the combinational alu32.
- Takes {op, a, b} on a valid/ready input channel.
- Returns {r, zero, overflow} on a valid/ready output channel.
- MULT uses an iterative shift-add datapath; all other ops complete in one cycle.
- Sits between the control/issue logic and the register write-back path in the multi-cycle processor variant.

Parameters:
WIDTH, 32, operand/result width; MULT iteration count equals WIDTH
CNT_W, 16, width of the completed-operation counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand/opcode request valid
in_ready  output  1  block can accept a request
op  input  3  opcode: 000 ADD, 001 XOR, 010 SUB, 011 MULT, 100 SLT, 101 NOR, 110 AND, 111 OR
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
r  output  WIDTH  result
zero  output  1  r == 0
overflow  output  1  signed overflow (ADD/SUB), or nonzero upper product half (MULT); 0 otherwise
op_count  output  CNT_W  number of results consumed since reset

Behaviour:
Interface decision (fixed): one clock, clk; reset is synchronous and active-high, named reset.

Reset (rst sampled high at a clk edge):
- state <= IDLE.
- in_ready=1, out_valid=0, r=0, zero=0, overflow=0, op_count=0.
- Reset overrides every other event. An operation in flight is aborted with no result.

States:
- IDLE: in_ready=1, out_valid=0. On in_valid&in_ready, capture op, a, b.
  - op=011: go to MUL; load multiplicand=a (zero-extended to 2*WIDTH), multiplier=b, acc=0, step=0.
  - otherwise: compute the result combinationally from the captured-at-edge inputs, register r/zero/overflow, go to DONE.
- MUL: in_ready=0. Each cycle:
  - if multiplier[0], then acc += multiplicand;
  - multiplicand <<= 1; multiplier >>= 1; step++.
  - After the WIDTH-th iteration (step==WIDTH-1 this cycle): r=acc[WIDTH-1:0], overflow=|acc[2*WIDTH-1:WIDTH], zero=(r==0); go to DONE.
  - The MUL state is never skipped, even when b==0.
- DONE: out_valid=1, in_ready=0. r/zero/overflow stay stable until out_ready is sampled high. On out_valid&out_ready: op_count++ (wraps at 2^CNT_W), go to IDLE.

Latency:
- Non-MULT: out_valid high in the cycle after the accept edge (1 cycle).
- MULT: out_valid high WIDTH+1 cycles after the accept edge.
- Earliest next accept: the cycle after result handshake (no same-cycle accept in DONE). Throughput is 1 op per 2 cycles for non-MULT ops.

Arithmetic rules:
- ADD/SUB: modulo 2^WIDTH. overflow = operand sign bits (b inverted for SUB) agree and r sign differs.
- SLT: signed compare; r = 1 if a<b, else 0; overflow=0.
- XOR/NOR/AND/OR: bitwise; overflow=0.
- MULT: unsigned product, low half returned.
- zero is valid for every op.

Boundary conditions:
- in_valid while not IDLE: ignored. Inputs are don't-care outside the accept cycle.
- out_ready high while out_valid=0: no effect.
- in_valid dropping before accept: no effect, nothing captured.
- op_count wrap: 0xFFFF+1 -> 0x0000 at CNT_W=16.

Test Plan:
- Reset, then ADD a=0x33333333 b=0x33333333 with out_ready=1 -> out_valid 1 cycle after accept; r=0x66666666, zero=0, overflow=0; op_count=1.
- ADD 0xFFFFFFFF+0xFFFFFFFF -> r=0xFFFFFFFE, overflow=0. ADD 0x7FFFFFFF+0x00000001 -> r=0x80000000, overflow=1.
- SUB 0x55555555-0x55555555 -> r=0, zero=1. SLT 0x00000333 vs 0x33333333 -> r=1. SLT 0x55555555 vs 0x1D551D55 -> r=0, zero=1.
- MULT 0x81122500*0x00600000 -> out_valid exactly 33 cycles after accept; r=0xE0000000, overflow=1; in_ready=0 throughout. MULT 0x00000003*0x00000005 -> r=0x0000000F, overflow=0.
- Backpressure: XOR 0xB3333333^0x33333333 with out_ready low for 5 cycles -> r=0x80000000 held stable, out_valid=1, in_ready=0; new in_valid is ignored; the op is consumed when out_ready rises.
- Reset asserted in cycle 10 of a MULT -> next cycle in_ready=1, out_valid=0, r=0, op_count=0; a following AND 0xB3333333&0x33333333 returns r=0x33333333.
